// File: rtl/psg_bus_interface.sv
// PSG bus-side register writer: BDIR/BC1 decode into R0..R15.
// Optional readback mux enabled by defining PSG_BUS_READBACK_EN.
module psg_bus_interface #(
   parameter logic [3:0] ADDR_HI     = 4'h0,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bdir,
   input  logic        bc1,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic [11:0] tone_a_period,
   output logic [11:0] tone_b_period,
   output logic [11:0] tone_c_period,
   output logic [4:0]  noise_period,
   output logic [7:0]  mixer,
   output logic [4:0]  amp_a,
   output logic [4:0]  amp_b,
   output logic [4:0]  amp_c,
   output logic [15:0] envelope_period,
   output logic        env_continue,
   output logic        env_attack,
   output logic        env_alternate,
   output logic        env_hold,
   output logic        env_restart
);

   typedef enum logic [1:0] {
      CMD_INACTIVE = 2'b00,
      CMD_READ     = 2'b01,
      CMD_WRITE    = 2'b10,
      CMD_LATCH    = 2'b11
   } cmd_t;

   logic [SYNC_STAGES-1:0] bdir_sync;
   logic [SYNC_STAGES-1:0] bc1_sync;
   logic [7:0]             data_sync [SYNC_STAGES];
   logic [7:0]             data_hold;
   logic [7:0]             regs [16];
   logic [3:0]             addr;
   logic                   selected;
   cmd_t                   cmd;
   cmd_t                   prev_cmd;
   logic                   commit_latch;
   logic                   commit_write;

   function automatic logic [7:0] reg_mask(input logic [3:0] a);
      case (a)
         4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
         4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
         default:                 reg_mask = 8'hFF;
      endcase
   endfunction

   // Shift bus pins through the synchronizer chains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bdir_sync <= '0;
         bc1_sync  <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= 8'h00;
      end else begin
         bdir_sync    <= {bdir_sync[SYNC_STAGES-2:0], bdir};
         bc1_sync     <= {bc1_sync[SYNC_STAGES-2:0], bc1};
         data_sync[0] <= data_in;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      end
   end

   // Decode synchronized command; without readback a READ looks idle
   always_comb begin
      cmd = cmd_t'({bdir_sync[SYNC_STAGES-1], bc1_sync[SYNC_STAGES-1]});
`ifndef PSG_BUS_READBACK_EN
      if (cmd == CMD_READ) cmd = CMD_INACTIVE;
`endif
   end

   // Command state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_cmd <= CMD_INACTIVE;
      else        prev_cmd <= cmd;
   end

   // Commit the operation of the state being left
   always_comb begin
      commit_latch = 1'b0;
      commit_write = 1'b0;
      if (prev_cmd != cmd) begin
         unique case (prev_cmd)
            CMD_LATCH: commit_latch = 1'b1;
            CMD_WRITE: commit_write = selected;
            default:   ;
         endcase
      end
   end

   // Data hold, address latch, register file and restart pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_hold   <= 8'h00;
         addr        <= 4'h0;
         selected    <= 1'b1;
         env_restart <= 1'b0;
         for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      end else begin
         if (cmd == CMD_WRITE || cmd == CMD_LATCH)
            data_hold <= data_sync[SYNC_STAGES-1];
         if (commit_latch) begin
            addr     <= data_hold[3:0];
            selected <= (data_hold[7:4] == ADDR_HI);
         end
         if (commit_write)
            regs[addr] <= data_hold & reg_mask(addr);
         env_restart <= commit_write && (addr == 4'd13);
      end
   end

`ifdef PSG_BUS_READBACK_EN
   // Registered read mux, live while a selected READ is on the bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_oe  <= 1'b0;
         data_out <= 8'h00;
      end else if (cmd == CMD_READ && selected) begin
         data_oe  <= 1'b1;
         data_out <= regs[addr];
      end else begin
         data_oe  <= 1'b0;
         data_out <= 8'h00;
      end
   end
`else
   assign data_oe  = 1'b0;
   assign data_out = 8'h00;
`endif

   assign tone_a_period   = {regs[1][3:0], regs[0]};
   assign tone_b_period   = {regs[3][3:0], regs[2]};
   assign tone_c_period   = {regs[5][3:0], regs[4]};
   assign noise_period    = regs[6][4:0];
   assign mixer           = regs[7];
   assign amp_a           = regs[8][4:0];
   assign amp_b           = regs[9][4:0];
   assign amp_c           = regs[10][4:0];
   assign envelope_period = {regs[12], regs[11]};
   assign env_continue    = regs[13][3];
   assign env_attack      = regs[13][2];
   assign env_alternate   = regs[13][1];
   assign env_hold        = regs[13][0];

endmodule

// File: tb/tb_psg_bus_interface.sv
// Directed bench for psg_bus_interface.
// Expected read results follow PSG_BUS_READBACK_EN.
module tb_psg_bus_interface;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bdir = 1'b0;
   logic        bc1 = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [11:0] tone_a_period, tone_b_period, tone_c_period;
   logic [4:0]  noise_period;
   logic [7:0]  mixer;
   logic [4:0]  amp_a, amp_b, amp_c;
   logic [15:0] envelope_period;
   logic        env_continue, env_attack, env_alternate, env_hold;
   logic        env_restart;

   int tests = 0;
   int fails = 0;
   int pulses = 0;

`ifdef PSG_BUS_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   psg_bus_interface dut (
      .clk(clk), .rst_n(rst_n), .bdir(bdir), .bc1(bc1),
      .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
      .tone_a_period(tone_a_period), .tone_b_period(tone_b_period),
      .tone_c_period(tone_c_period), .noise_period(noise_period),
      .mixer(mixer), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
      .envelope_period(envelope_period),
      .env_continue(env_continue), .env_attack(env_attack),
      .env_alternate(env_alternate), .env_hold(env_hold),
      .env_restart(env_restart)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (env_restart === 1'b1) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hold a bus command for 3 clocks, then drop to INACTIVE
   task automatic cyc(input logic [1:0] c, input logic [7:0] v);
      @(negedge clk);
      {bdir, bc1} = c;
      data_in = v;
      repeat (3) @(negedge clk);
      {bdir, bc1} = 2'b00;
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic latch(input logic [7:0] v);
      cyc(2'b11, v);
      wait_edges(3);
   endtask

   task automatic write(input logic [7:0] v);
      cyc(2'b10, v);
      wait_edges(3);
   endtask

   initial begin
      int p0;
      repeat (3) @(negedge clk);
      chk("reset_env_period", envelope_period, 0);
      chk("reset_mixer", mixer, 0);
      rst_n = 1'b1;
      wait_edges(6);
      chk("idle_tone_a", tone_a_period, 0);
      chk("idle_env_bits",
          {env_continue, env_attack, env_alternate, env_hold}, 0);
      chk("idle_oe", data_oe, 0);
      chk("idle_out", data_out, 0);
      chk("idle_pulses", pulses, 0);

      latch(8'h0B);
      cyc(2'b10, 8'h34);
      wait_edges(2);
      chk("lat_before", envelope_period, 16'h0000);
      wait_edges(1);
      chk("lat_after", envelope_period, 16'h0034);
      latch(8'h0C);
      write(8'h12);
      chk("env_period", envelope_period, 16'h1234);

      latch(8'h0D);
      cyc(2'b10, 8'hFE);
      wait_edges(3);
      chk("restart_on_commit", env_restart, 1);
      chk("env_bits",
          {env_continue, env_attack, env_alternate, env_hold}, 4'hE);
      wait_edges(1);
      chk("restart_one_clk", env_restart, 0);
      chk("pulses_1", pulses, 1);
      write(8'hFE);
      wait_edges(2);
      chk("pulses_2", pulses, 2);

      latch(8'h01);
      write(8'hFF);
      chk("tone_a_mask", tone_a_period, 12'hF00);
      @(negedge clk);
      {bdir, bc1} = 2'b01;
      wait_edges(3);
      chk("read_oe", data_oe, RB ? 1 : 0);
      chk("read_data", data_out, RB ? 8'h0F : 8'h00);
      @(negedge clk);
      {bdir, bc1} = 2'b00;
      wait_edges(4);
      chk("read_end_oe", data_oe, 0);

      latch(8'h06);
      write(8'hFF);
      chk("noise_mask", noise_period, 5'h1F);
      latch(8'h07);
      write(8'hA5);
      chk("mixer", mixer, 8'hA5);

      p0 = pulses;
      latch(8'h18);
      write(8'h55);
      chk("desel_amp_a", amp_a, 0);
      latch(8'h1D);
      write(8'h03);
      wait_edges(2);
      chk("desel_no_pulse", pulses, p0);
      chk("desel_env_bits",
          {env_continue, env_attack, env_alternate, env_hold}, 4'hE);
      @(negedge clk);
      {bdir, bc1} = 2'b01;
      wait_edges(3);
      chk("desel_read_oe", data_oe, 0);
      @(negedge clk);
      {bdir, bc1} = 2'b00;
      wait_edges(3);
      latch(8'h08);
      write(8'h55);
      chk("resel_amp_a", amp_a, 5'h15);

      latch(8'h07);
      @(negedge clk);
      {bdir, bc1} = 2'b10;
      data_in = 8'h3C;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mixer", mixer, 0);
      chk("rst_amp_a", amp_a, 0);
      @(negedge clk);
      {bdir, bc1} = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      wait_edges(6);
      chk("rst_no_commit", mixer, 0);
      chk("rst_env_period", envelope_period, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
